// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER fetch unit and its fetch buffer.
package otter_fetch_pkg;

  localparam int unsigned PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // The entry PC is stored beside this struct so that its width can follow ADDR_W.
  typedef struct packed {
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/otter_fetch_buf.sv
// Circular fetch buffer: entries are allocated at request grant, filled in order as
// read data returns, and popped in order by decode. A flush empties it in one edge.
module otter_fetch_buf
  import otter_fetch_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [31:0]       fill_instr,
  input  logic              pop,
  output logic              head_filled,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_instr,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     pending
);

  fetch_entry_t      ent_r [DEPTH];
  logic [ADDR_W-1:0] pc_r  [DEPTH];
  logic [PW-1:0]     alloc_ptr_r;
  logic [PW-1:0]     fill_ptr_r;
  logic [PW-1:0]     head_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     pending_r;

  // Entry storage, pointers and occupancy counters; flush wins over every update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '{instr: INSTR_NOP, filled: 1'b0};
        pc_r[i]  <= '0;
      end
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      count_r     <= '0;
      pending_r   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i].filled <= 1'b0;
      end
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      count_r     <= '0;
      pending_r   <= '0;
    end else begin
      if (alloc) begin
        ent_r[alloc_ptr_r] <= '{instr: INSTR_NOP, filled: 1'b0};
        pc_r[alloc_ptr_r]  <= alloc_pc;
        alloc_ptr_r        <= alloc_ptr_r + PW'(1);
      end
      // Fill and alloc never hit the same slot: alloc needs a free slot, fill targets a used one.
      if (fill) begin
        ent_r[fill_ptr_r] <= '{instr: fill_instr, filled: 1'b1};
        fill_ptr_r        <= fill_ptr_r + PW'(1);
      end
      if (pop) begin
        head_ptr_r <= head_ptr_r + PW'(1);
      end
      count_r   <= count_r + CW'(alloc) - CW'(pop);
      pending_r <= pending_r + CW'(alloc) - CW'(fill);
    end
  end

  assign head_filled = ent_r[head_ptr_r].filled;
  assign head_instr  = ent_r[head_ptr_r].instr;
  assign head_pc     = pc_r[head_ptr_r];
  assign count       = count_r;
  assign pending     = pending_r;

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: in-order imem requests, fetch buffer, redirect kill.
// Optional macro OTTER_FETCH_BYPASS_EN forwards returning read data straight to decode.
module otter_fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int CW     = cnt_w(DEPTH)
) (
  input  logic              IF_CLK,
  input  logic              IF_RST_N,
  input  logic [ADDR_W-1:0] IF_PC,
  output logic              IF_PC_LD,
  output logic [ADDR_W-1:0] IF_PC_DIN,
  input  logic              IF_REDIRECT,
  input  logic [ADDR_W-1:0] IF_REDIRECT_ADDR,
  output logic              IF_MEM_REQ,
  output logic [ADDR_W-1:0] IF_MEM_ADDR,
  input  logic              IF_MEM_GNT,
  input  logic              IF_MEM_RVALID,
  input  logic [31:0]       IF_MEM_RDATA,
  output logic              IF_DEC_VALID,
  input  logic              IF_DEC_READY,
  output logic [31:0]       IF_DEC_INSTR,
  output logic [ADDR_W-1:0] IF_DEC_PC
);

  localparam int SW = CW + 1;

  logic              run_r;
  logic [CW-1:0]     kill_r;
  logic [CW-1:0]     kill_nxt_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     pending_s;
  logic [CW-1:0]     outstanding_s;
  logic              room_s;
  logic              head_filled_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic [31:0]       head_instr_s;
  logic [ADDR_W-1:0] redirect_tgt_s;
  logic              mem_req_s;
  logic              alloc_s;
  logic              fill_s;
  logic              pop_s;
  logic              flush_s;
  logic              bypass_s;
  logic              pc_ld_s;
  logic [ADDR_W-1:0] pc_din_s;
  logic              dec_valid_s;
  logic [31:0]       dec_instr_s;
  logic [ADDR_W-1:0] dec_pc_s;

  otter_fetch_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk         (IF_CLK),
    .rst_n       (IF_RST_N),
    .flush       (flush_s),
    .alloc       (alloc_s),
    .alloc_pc    (IF_PC),
    .fill        (fill_s),
    .fill_instr  (IF_MEM_RDATA),
    .pop         (pop_s),
    .head_filled (head_filled_s),
    .head_pc     (head_pc_s),
    .head_instr  (head_instr_s),
    .count       (count_s),
    .pending     (pending_s)
  );

  // Killed plus live in-flight requests never exceed DEPTH, so the CW-bit sum cannot wrap.
  assign outstanding_s  = kill_r + pending_s;
  assign room_s         = ({1'b0, kill_r} + {1'b0, count_s}) < SW'(DEPTH);
  assign redirect_tgt_s = IF_REDIRECT_ADDR & ~ADDR_W'(3);

  // Outputs stay quiet until the first edge after reset release.
  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Count of responses still owed to requests that a redirect has made stale.
  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      kill_r <= '0;
    end else begin
      kill_r <= kill_nxt_s;
    end
  end

  // Request gating, PC next-value mux, kill accounting and decode presentation.
  always_comb begin
    mem_req_s   = 1'b0;
    alloc_s     = 1'b0;
    fill_s      = 1'b0;
    pop_s       = 1'b0;
    flush_s     = 1'b0;
    bypass_s    = 1'b0;
    pc_ld_s     = 1'b0;
    pc_din_s    = '0;
    dec_valid_s = 1'b0;
    dec_instr_s = '0;
    dec_pc_s    = '0;
    kill_nxt_s  = kill_r;
    if (!run_r) begin
      kill_nxt_s = '0;
    end else if (IF_REDIRECT) begin
      pc_ld_s  = 1'b1;
      pc_din_s = redirect_tgt_s;
      flush_s  = 1'b1;
      // A response arriving in this cycle is discarded now, so it is not owed later.
      if (IF_MEM_RVALID && (outstanding_s != '0)) begin
        kill_nxt_s = outstanding_s - CW'(1);
      end else begin
        kill_nxt_s = outstanding_s;
      end
    end else begin
      mem_req_s = room_s;
      alloc_s   = room_s & IF_MEM_GNT;
      if (alloc_s) begin
        pc_ld_s  = 1'b1;
        pc_din_s = IF_PC + ADDR_W'(PC_STEP);
      end else begin
        pc_ld_s  = 1'b0;
      end
      if (IF_MEM_RVALID && (kill_r != '0)) begin
        kill_nxt_s = kill_r - CW'(1);
      end else if (IF_MEM_RVALID && (pending_s != '0)) begin
        fill_s = 1'b1;
      end else begin
        fill_s = 1'b0;
      end
`ifdef OTTER_FETCH_BYPASS_EN
      // An unfilled head is always the next entry to be filled, so the word can go straight out.
      bypass_s = fill_s && !head_filled_s && (count_s != '0);
`else
      bypass_s = 1'b0;
`endif
      if ((count_s != '0) && head_filled_s) begin
        dec_valid_s = 1'b1;
        dec_instr_s = head_instr_s;
        dec_pc_s    = head_pc_s;
      end else if (bypass_s) begin
        dec_valid_s = 1'b1;
        dec_instr_s = IF_MEM_RDATA;
        dec_pc_s    = head_pc_s;
      end else begin
        dec_valid_s = 1'b0;
      end
      pop_s = dec_valid_s & IF_DEC_READY;
    end
  end

  assign IF_MEM_REQ   = mem_req_s;
  assign IF_MEM_ADDR  = run_r ? IF_PC : '0;
  assign IF_PC_LD     = pc_ld_s;
  assign IF_PC_DIN    = pc_din_s;
  assign IF_DEC_VALID = dec_valid_s;
  assign IF_DEC_INSTR = dec_instr_s;
  assign IF_DEC_PC    = dec_pc_s;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Scoreboard bench for otter_fetch_unit: bench models the PC register and an in-order imem.
module tb_otter_fetch_unit;

`ifdef OTTER_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IF_PC;
  logic        IF_PC_LD;
  logic [31:0] IF_PC_DIN;
  logic        IF_REDIRECT;
  logic [31:0] IF_REDIRECT_ADDR;
  logic        IF_MEM_REQ;
  logic [31:0] IF_MEM_ADDR;
  logic        IF_MEM_GNT;
  logic        IF_MEM_RVALID;
  logic [31:0] IF_MEM_RDATA;
  logic        IF_DEC_VALID;
  logic        IF_DEC_READY;
  logic [31:0] IF_DEC_INSTR;
  logic [31:0] IF_DEC_PC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem_q[$];
  bit          rv_en;
  int          checks = 0;
  int          errors = 0;

  logic        env_g, env_ld, env_rv, env_rven;
  logic [31:0] env_a, env_din;

  always #5 clk = ~clk;

  otter_fetch_unit #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .IF_CLK           (clk),
    .IF_RST_N         (rst_n),
    .IF_PC            (IF_PC),
    .IF_PC_LD         (IF_PC_LD),
    .IF_PC_DIN        (IF_PC_DIN),
    .IF_REDIRECT      (IF_REDIRECT),
    .IF_REDIRECT_ADDR (IF_REDIRECT_ADDR),
    .IF_MEM_REQ       (IF_MEM_REQ),
    .IF_MEM_ADDR      (IF_MEM_ADDR),
    .IF_MEM_GNT       (IF_MEM_GNT),
    .IF_MEM_RVALID    (IF_MEM_RVALID),
    .IF_MEM_RDATA     (IF_MEM_RDATA),
    .IF_DEC_VALID     (IF_DEC_VALID),
    .IF_DEC_READY     (IF_DEC_READY),
    .IF_DEC_INSTR     (IF_DEC_INSTR),
    .IF_DEC_PC        (IF_DEC_PC)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d instructions undelivered after %0d cycles, expected 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // Monitor: every accepted decode transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && IF_DEC_VALID === 1'b1 && IF_DEC_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h instr %h, expected no delivery",
                 IF_DEC_PC, IF_DEC_INSTR);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dec_pc", IF_DEC_PC, mon_e.pc);
        chk("dec_instr", IF_DEC_INSTR, mon_e.instr);
      end
    end
  end

  // Environment: program-counter register and in-order imem returning data 1 cycle after grant.
  initial begin
    forever begin
      @(negedge clk);
      env_g    = IF_MEM_REQ & IF_MEM_GNT;
      env_a    = IF_MEM_ADDR;
      env_ld   = IF_PC_LD;
      env_din  = IF_PC_DIN;
      env_rv   = IF_MEM_RVALID;
      env_rven = rv_en;
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        IF_PC = 32'h0;
        mem_q.delete();
        IF_MEM_RVALID = 1'b0;
        IF_MEM_RDATA  = 32'h0;
      end else begin
        if (env_ld) IF_PC = env_din;
        if (env_rv && mem_q.size() > 0) void'(mem_q.pop_front());
        if (env_g) mem_q.push_back(env_a);
        if (env_rven && mem_q.size() > 0) begin
          IF_MEM_RVALID = 1'b1;
          IF_MEM_RDATA  = instr_of(mem_q[0]);
        end else begin
          IF_MEM_RVALID = 1'b0;
          IF_MEM_RDATA  = 32'h0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; IF_PC = 32'h0; IF_MEM_RVALID = 1'b0; IF_MEM_RDATA = 32'h0;
    IF_MEM_GNT = 1'b0; IF_DEC_READY = 1'b0; IF_REDIRECT = 1'b0; IF_REDIRECT_ADDR = 32'h0;
    rv_en = 1'b1;
    #2;
    chk("rst_req", IF_MEM_REQ, 0);
    chk("rst_ld", IF_PC_LD, 0);
    chk("rst_din", IF_PC_DIN, 0);
    chk("rst_dec_valid", IF_DEC_VALID, 0);
    chk("rst_mem_addr", IF_MEM_ADDR, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("idle_req", IF_MEM_REQ, 1);
    chk("idle_ld", IF_PC_LD, 0);
    cyc();

    // 1: streaming fetch from PC 0 with 1-cycle memory and ready decode
    IF_DEC_READY = 1'b1;
    IF_MEM_GNT   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_pc(32'(4 * i));
      @(negedge clk);
      chk("t1_req", IF_MEM_REQ, 1);
      chk("t1_ld", IF_PC_LD, 1);
      chk("t1_din", IF_PC_DIN, 32'(4 * (i + 1)));
      if (i == 1) chk("t1_latency1", IF_DEC_VALID, {31'b0, BYP});
      if (i == 2) chk("t1_latency2", IF_DEC_VALID, 1);
      cyc();
    end
    IF_MEM_GNT = 1'b0;
    @(negedge clk);
    chk("t1_req_held", IF_MEM_REQ, 1);
    chk("t1_ld_no_gnt", IF_PC_LD, 0);
    drain("t1");

    // 2: decode stalled -> exactly DEPTH grants, then drain in order
    IF_DEC_READY = 1'b0;
    IF_MEM_GNT   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_pc(32'(24 + 4 * i));
      @(negedge clk);
      chk("t2_req", IF_MEM_REQ, (i < 4) ? 32'd1 : 32'd0);
      chk("t2_ld", IF_PC_LD, (i < 4) ? 32'd1 : 32'd0);
      if (i == 5) chk("t2_valid_full", IF_DEC_VALID, 1);
      cyc();
    end
    IF_MEM_GNT   = 1'b0;
    IF_DEC_READY = 1'b1;
    drain("t2");

    // 3: three requests in flight, redirect to 0x100 kills their responses
    rv_en      = 1'b0;
    IF_MEM_GNT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_pre_din", IF_PC_DIN, 32'(44 + 4 * i));
      cyc();
    end
    IF_MEM_GNT       = 1'b0;
    IF_REDIRECT      = 1'b1;
    IF_REDIRECT_ADDR = 32'h100;
    rv_en            = 1'b1;
    @(negedge clk);
    chk("t3_redir_ld", IF_PC_LD, 1);
    chk("t3_redir_din", IF_PC_DIN, 32'h100);
    chk("t3_redir_req", IF_MEM_REQ, 0);
    chk("t3_redir_valid", IF_DEC_VALID, 0);
    cyc();
    IF_REDIRECT = 1'b0;
    IF_MEM_GNT  = 1'b1;
    expect_pc(32'h100);
    expect_pc(32'h104);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_kill_req", IF_MEM_REQ, 1);
      chk("t3_post_din", IF_PC_DIN, 32'(32'h104 + 4 * i));
      cyc();
    end
    IF_MEM_GNT = 1'b0;
    drain("t3");

    // 4: misaligned redirect target and PC wrap at the top of the address space
    IF_REDIRECT      = 1'b1;
    IF_REDIRECT_ADDR = 32'h103;
    @(negedge clk);
    chk("t4_align_din", IF_PC_DIN, 32'h100);
    cyc();
    IF_REDIRECT_ADDR = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t4_top_din", IF_PC_DIN, 32'hFFFF_FFFC);
    cyc();
    IF_REDIRECT = 1'b0;
    IF_MEM_GNT  = 1'b1;
    expect_pc(32'hFFFF_FFFC);
    @(negedge clk);
    chk("t4_wrap_ld", IF_PC_LD, 1);
    chk("t4_wrap_din", IF_PC_DIN, 32'h0);
    cyc();
    IF_MEM_GNT = 1'b0;
    drain("t4");

    // 5: redirect in the same cycle as RVALID with decode ready
    IF_MEM_GNT = 1'b1;
    @(negedge clk);
    chk("t5_req", IF_MEM_REQ, 1);
    cyc();
    IF_MEM_GNT       = 1'b0;
    IF_REDIRECT      = 1'b1;
    IF_REDIRECT_ADDR = 32'h200;
    @(negedge clk);
    chk("t5_redir_valid", IF_DEC_VALID, 0);
    chk("t5_redir_din", IF_PC_DIN, 32'h200);
    cyc();
    IF_REDIRECT = 1'b0;
    IF_MEM_GNT  = 1'b1;
    expect_pc(32'h200);
    expect_pc(32'h204);
    repeat (2) cyc();
    IF_MEM_GNT = 1'b0;
    drain("t5");

    // 6: asynchronous reset in the middle of a burst
    IF_DEC_READY = 1'b0;
    IF_MEM_GNT   = 1'b1;
    repeat (3) cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_req", IF_MEM_REQ, 0);
    chk("t6_ld", IF_PC_LD, 0);
    chk("t6_din", IF_PC_DIN, 0);
    chk("t6_addr", IF_MEM_ADDR, 0);
    chk("t6_valid", IF_DEC_VALID, 0);
    chk("t6_instr", IF_DEC_INSTR, 0);
    chk("t6_pc", IF_DEC_PC, 0);
    IF_MEM_GNT = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("t6_post_req", IF_MEM_REQ, 1);
    chk("t6_post_valid", IF_DEC_VALID, 0);
    chk("t6_post_addr", IF_MEM_ADDR, 0);
    cyc();
    IF_DEC_READY = 1'b1;
    IF_MEM_GNT   = 1'b1;
    expect_pc(32'h0);
    @(negedge clk);
    chk("t6_post_din", IF_PC_DIN, 32'h4);
    cyc();
    IF_MEM_GNT = 1'b0;
    drain("t6");
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
